wb_arbiter: RTL and testbench

- Write-back arbiter: merges two result streams into the single write port (we/rwaddr/din) of the 32x32 register file.
- Primary stream: in-order ALU/pipeline results. It is never stalled and always has priority.
- Secondary stream: long-latency results (divider, slow loads). These are buffered in a DEPTH-entry FIFO and written in idle slots.
- Also provides a pending-write lookup for the hazard unit, plus a starvation stall request.

---
 rtl/wb_arbiter_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 120 ++++++++++++
 rtl/wb_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared CPU write-back types.
//   REG_ADDR_W / XLEN : register-file address and data widths
//   wb_req_t          : one write request {valid, addr, data}. It is used by the primary
//                       stream, the secondary stream and the register-file write port.
//   fifo_entry_t      : secondary FIFO slot. stored = slot occupied, req.valid = live
//                       (not yet superseded by a younger primary write).
package wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef struct packed {
        logic    stored;
        wb_req_t req;
    } fifo_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Secondary write-back FIFO with a live bit on each entry.
//   clk, rst_n            : clock and synchronous active-low reset
//   push_i, push_*_i      : enqueue {addr, data}. The new entry starts live. Ignored when full.
//   pop_i                 : drop the head entry. Ignored when empty.
//   kill_i, kill_addr_i   : clear the live bit of every stored entry that targets
//                           kill_addr_i. An entry pushed in the same cycle is not affected.
//   chk_addr_i            : address lookup. chk_pending_o = a stored live entry targets it.
//   head_o                : head entry. head_o.valid is its live bit.
//   count_o, full_o, empty_o : occupancy. Killed entries are included.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [REG_ADDR_W-1:0]      push_addr_i,
    input  logic [XLEN-1:0]            push_data_i,
    input  logic                       pop_i,
    input  logic                       kill_i,
    input  logic [REG_ADDR_W-1:0]      kill_addr_i,
    input  logic [REG_ADDR_W-1:0]      chk_addr_i,
    output logic                       chk_pending_o,
    output wb_req_t                    head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    fifo_entry_t       mem_q [DEPTH];
    fifo_entry_t       mem_d [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q].req;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        // Kill looks only at entries already stored, so it runs before the push below.
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].stored && (mem_q[i].req.addr == kill_addr_i)) begin
                    mem_d[i].req.valid = 1'b0;
                end
            end
        end

        if (pop_ok) begin
            mem_d[rd_ptr_q].stored    = 1'b0;
            mem_d[rd_ptr_q].req.valid = 1'b0;
            rd_ptr_d                  = rd_ptr_q + PtrOne;
        end

        // A push writes a free slot, which cannot be the head being popped.
        if (push_ok) begin
            mem_d[wr_ptr_q].stored    = 1'b1;
            mem_d[wr_ptr_q].req.valid = 1'b1;
            mem_d[wr_ptr_q].req.addr  = push_addr_i;
            mem_d[wr_ptr_q].req.data  = push_data_i;
            wr_ptr_d                  = wr_ptr_q + PtrOne;
        end

        if (push_ok && !pop_ok) begin
            count_d = count_q + CntOne;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CntOne;
        end
    end

    always_comb begin
        chk_pending_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].stored && mem_q[i].req.valid && (mem_q[i].req.addr == chk_addr_i)) begin
                chk_pending_o = 1'b1;
            end
        end
        // Register 0 is never a real destination.
        if (chk_addr_i == '0) begin
            chk_pending_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter. It merges the primary pipeline stream and the buffered
// secondary (long-latency) stream into the single register-file write port.
//   clk, rst_n                  : clock and synchronous active-low reset
//   p_valid/p_addr/p_data       : primary request. It has priority and is never stalled.
//   s_valid/s_ready/s_addr/s_data : secondary handshake. Entries go to a DEPTH-entry FIFO.
//   wb_we/wb_addr/wb_data       : registered register-file write port
//   chk_addr/chk_pending        : hazard lookup over live queued writes
//   stall_req                   : registered. Set after MAX_WAIT blocked cycles of the FIFO head.
//   count                       : FIFO occupancy. Killed entries are included.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       p_valid,
    input  logic [REG_ADDR_W-1:0]      p_addr,
    input  logic [XLEN-1:0]            p_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [REG_ADDR_W-1:0]      s_addr,
    input  logic [XLEN-1:0]            s_data,
    output logic                       wb_we,
    output logic [REG_ADDR_W-1:0]      wb_addr,
    output logic [XLEN-1:0]            wb_data,
    input  logic [REG_ADDR_W-1:0]      chk_addr,
    output logic                       chk_pending,
    output logic                       stall_req,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned WaitW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
    localparam logic [WaitW-1:0] WaitOne = WaitW'(1);

    wb_req_t          wb_q, wb_d;
    wb_req_t          head;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             stall_q, stall_d;

    logic             fifo_full, fifo_empty, fifo_chk;
    logic             push, pop, kill;

    // A full FIFO stays unready even when the head pops in the same cycle.
    assign s_ready = rst_n && !fifo_full;
    // Writes to r0 are accepted but never stored.
    assign push    = s_valid && s_ready && (s_addr != '0);
    assign pop     = !p_valid && !fifo_empty;
    // A granted primary write supersedes older queued writes to the same register.
    assign kill    = p_valid && (p_addr != '0);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (push),
        .push_addr_i   (s_addr),
        .push_data_i   (s_data),
        .pop_i         (pop),
        .kill_i        (kill),
        .kill_addr_i   (p_addr),
        .chk_addr_i    (chk_addr),
        .chk_pending_o (fifo_chk),
        .head_o        (head),
        .count_o       (count),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty)
    );

    assign chk_pending = rst_n && fifo_chk;

    always_comb begin
        // Address and data hold their last values on idle slots.
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        if (p_valid) begin
            if (p_addr != '0) begin
                wb_d.valid = 1'b1;
                wb_d.addr  = p_addr;
                wb_d.data  = p_data;
            end
        end else if (pop) begin
            // A killed head uses its slot but does not write.
            if (head.valid) begin
                wb_d.valid = 1'b1;
                wb_d.addr  = head.addr;
                wb_d.data  = head.data;
            end
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (p_valid && (wait_q != WaitMax)) begin
            wait_d = wait_q + WaitOne;
        end
        // Registered together with wait_q, so stall_req tracks wait_q >= MAX_WAIT.
        stall_d = (wait_d >= WaitMax);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q    <= '0;
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wb_q    <= wb_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign wb_we     = wb_q.valid;
    assign wb_addr   = wb_q.addr;
    assign wb_data   = wb_q.data;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_valid = 1'b0;
    logic [4:0]  p_addr = '0;
    logic [31:0] p_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  s_addr = '0;
    logic [31:0] s_data = '0;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  chk_addr = '0;
    logic        chk_pending;
    logic        stall_req;
    logic [2:0]  count;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p_valid     (p_valid),
        .p_addr      (p_addr),
        .p_data      (p_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_addr      (s_addr),
        .s_data      (s_data),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending),
        .stall_req   (stall_req),
        .count       (count)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          live;
    } ent_t;

    // Reference model state.
    ent_t        q[$];
    int          wait_m = 0;
    bit          stall_m = 0;
    bit          we_m = 0;
    logic [4:0]  addr_m = '0;
    logic [31:0] data_m = '0;
    logic [31:0] rf_m   [32];
    logic [31:0] rf_dut [32];
    logic        pre_ready, pre_chk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit rst, input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                        input bit sv, input logic [4:0] sa, input logic [31:0] sd,
                        input logic [4:0] ca);
        bit   m_ready, m_chk, popped, was_empty;
        ent_t e;
        @(negedge clk);
        rst_n = rst; p_valid = pv; p_addr = pa; p_data = pd;
        s_valid = sv; s_addr = sa; s_data = sd; chk_addr = ca;
        #1;
        m_ready = rst && (q.size() != DEPTH);
        m_chk   = 1'b0;
        if (rst && ca != 0) begin
            foreach (q[i]) if (q[i].live && q[i].addr == ca) m_chk = 1'b1;
        end
        chk("s_ready", s_ready, m_ready);
        chk("chk_pending", chk_pending, m_chk);
        pre_ready = s_ready;
        pre_chk   = chk_pending;

        if (!rst) begin
            q.delete();
            wait_m = 0; stall_m = 0; we_m = 0; addr_m = '0; data_m = '0;
        end else begin
            popped    = 1'b0;
            was_empty = (q.size() == 0);
            if (pv) begin
                we_m = (pa != 0);
                if (pa != 0) begin
                    addr_m = pa; data_m = pd;
                    foreach (q[i]) if (q[i].addr == pa) q[i].live = 1'b0;
                end
            end else if (q.size() != 0) begin
                e = q.pop_front();
                popped = 1'b1;
                we_m = e.live;
                if (e.live) begin addr_m = e.addr; data_m = e.data; end
            end else begin
                we_m = 1'b0;
            end
            if (popped || was_empty) wait_m = 0;
            else if (pv) wait_m++;
            stall_m = (wait_m >= MAX_WAIT);
            if (sv && m_ready && sa != 0) q.push_back('{addr: sa, data: sd, live: 1'b1});
        end
        if (we_m) rf_m[addr_m] = data_m;

        @(posedge clk);
        #1;
        chk("wb_we", wb_we, we_m);
        chk("wb_addr", wb_addr, addr_m);
        chk("wb_data", wb_data, data_m);
        chk("stall_req", stall_req, stall_m);
        chk("count", count, q.size());
        if (wb_we) rf_dut[wb_addr] = wb_data;
    endtask

    task automatic idle(input logic [4:0] ca);
        step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, ca);
    endtask

    initial begin
        int n;
        bit r, pv, sv;
        for (int i = 0; i < 32; i++) begin rf_m[i] = '0; rf_dut[i] = '0; end

        // Reset then idle.
        for (int i = 0; i < 3; i++) step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0);
        idle(5'd0);
        chk("idle_we", wb_we, 0);
        chk("idle_count", count, 0);
        chk("idle_s_ready", pre_ready, 1);
        chk("idle_stall", stall_req, 0);

        // Primary only.
        step(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 5'd0);
        chk("prim_we", wb_we, 1);
        chk("prim_addr", wb_addr, 5);
        chk("prim_data", wb_data, 32'hDEADBEEF);
        step(1, 1, 5'd0, 32'h12345678, 0, 5'd0, 32'h0, 5'd0);
        chk("prim_r0_we", wb_we, 0);

        // Secondary fill while primary is busy, then starvation and drain.
        for (int i = 1; i <= 4; i++)
            step(1, 1, 5'd9, 32'h1, 1, 5'(i), 32'h100 + i, 5'd0);
        chk("fill_count", count, 4);
        step(1, 1, 5'd9, 32'h1, 1, 5'd5, 32'h105, 5'd0);
        chk("fill_fifth_ready", pre_ready, 0);
        n = 5;
        while (!stall_m && n < 20) begin
            step(1, 1, 5'd9, 32'h1, 0, 5'd0, 32'h0, 5'd0);
            n++;
        end
        chk("stall_set", stall_req, 1);
        chk("stall_cycle", n, 9);
        for (int i = 1; i <= 4; i++) begin
            idle(5'd0);
            chk("drain_we", wb_we, 1);
            chk("drain_addr", wb_addr, i);
            chk("drain_data", wb_data, 32'h100 + i);
        end
        chk("drain_count", count, 0);
        chk("drain_stall", stall_req, 0);

        // WAW kill.
        step(1, 0, 5'd0, 32'h0, 1, 5'd7, 32'h11, 5'd7);
        step(1, 1, 5'd7, 32'h22, 0, 5'd0, 32'h0, 5'd7);
        chk("waw_pending_before", pre_chk, 1);
        chk("waw_prim_addr", wb_addr, 7);
        chk("waw_prim_data", wb_data, 32'h22);
        idle(5'd7);
        chk("waw_pending_after", pre_chk, 0);
        chk("waw_pop_we", wb_we, 0);
        chk("waw_rf7", rf_dut[7], 32'h22);

        // Full boundary with head popping.
        for (int i = 0; i < 4; i++)
            step(1, 1, 5'd9, 32'h2, 1, 5'(10 + i), 32'h200 + i, 5'd0);
        step(1, 0, 5'd0, 32'h0, 1, 5'd20, 32'h220, 5'd0);
        chk("full_pop_ready", pre_ready, 0);
        chk("full_pop_count", count, 3);
        step(1, 1, 5'd9, 32'h2, 1, 5'd20, 32'h220, 5'd0);
        chk("full_next_ready", pre_ready, 1);
        chk("full_next_count", count, 4);
        for (int i = 0; i < 4; i++) idle(5'd0);
        chk("full_last_addr", wb_addr, 20);

        // Reset mid-operation.
        for (int i = 0; i < 3; i++)
            step(1, 1, 5'd9, 32'h3, 1, 5'(14 + i), 32'h300 + i, 5'd0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd14);
        chk("rst_mid_count", count, 0);
        for (int i = 0; i < 32; i++) idle(5'(i));

        // Randomized traffic, honouring stall_req.
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 199) != 0);
            pv = stall_m ? 1'b0 : ($urandom_range(0, 99) < 60);
            sv = ($urandom_range(0, 99) < 50);
            step(r, pv, 5'($urandom_range(0, 7)), $urandom,
                 sv, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
        end
        for (int i = 1; i < 32; i++) chk("rf_final", rf_dut[i], rf_m[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
